// File: rtl/skid_reg.sv
// skid_reg: two-entry valid/ready pipeline stage; both handshake directions leave from flops, din->dout latency 1 cycle.
// Backpressure: the skid entry absorbs the item in flight when dout stalls; din_ready drops the cycle after it fills.
module skid_reg #(
  parameter int             DIN        = 16,
  parameter logic [DIN-1:0] INIT       = '0,
  parameter bit             INIT_VALID = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DIN-1:0] din_data,
  input  logic           din_valid,
  output logic           din_ready,
  output logic [DIN-1:0] dout_data,
  output logic           dout_valid,
  input  logic           dout_ready
);

  // Encoding chosen so that bit 1 is din_ready and bit 0 is dout_valid.
  typedef enum logic [1:0] {
    FULL  = 2'b01,
    EMPTY = 2'b10,
    BUSY  = 2'b11
  } state_t;

  localparam state_t RST_STATE = INIT_VALID ? BUSY : EMPTY;

  state_t         state;
  state_t         state_nxt;
  logic [DIN-1:0] main_q;
  logic [DIN-1:0] skid_q;
  logic           main_ld;
  logic           main_from_skid;
  logic           skid_ld;
  logic           in_xfer;
  logic           out_xfer;

  assign din_ready  = state[1];
  assign dout_valid = state[0];
  assign dout_data  = main_q;

  assign in_xfer  = din_valid & din_ready;
  assign out_xfer = dout_valid & dout_ready;

  always_comb begin
    state_nxt      = state;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          main_ld   = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          main_ld = 1'b1;
        end else if (in_xfer) begin
          skid_ld   = 1'b1;
          state_nxt = FULL;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_STATE;
      if (INIT_VALID) main_q <= INIT;
    end else begin
      state <= state_nxt;
      if (main_ld) main_q <= main_from_skid ? skid_q : din_data;
    end
  end

  // Skid entry carries no reset: its content only matters while in FULL.
  always_ff @(posedge clk) begin
    if (skid_ld && !rst) skid_q <= din_data;
  end

  a_dout_hold: assert property (@(posedge clk) disable iff (rst)
    (dout_valid && !dout_ready) |=> (dout_valid && $stable(dout_data)));

  a_legal_state: assert property (@(posedge clk) disable iff (rst)
    (state != 2'b00));

endmodule

// File: tb/tb_skid_reg.sv
// Directed and randomized checks of skid_reg: reset, streaming, fill/drain, alternating ready, reset in FULL, INIT item.
module tb_skid_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din_data = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [15:0] dout_data;
  logic        dout_valid;
  logic        dout_ready = 1'b0;

  logic [15:0] i_din_data = '0;
  logic        i_din_valid = 1'b0;
  logic        i_din_ready;
  logic [15:0] i_dout_data;
  logic        i_dout_valid;
  logic        i_dout_ready = 1'b0;

  int checks = 0;
  int passed = 0;

  skid_reg #(.DIN(16), .INIT(16'h0000), .INIT_VALID(1'b0)) dut (
    .clk(clk), .rst(rst),
    .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  skid_reg #(.DIN(16), .INIT(16'h005A), .INIT_VALID(1'b1)) u_init (
    .clk(clk), .rst(rst),
    .din_data(i_din_data), .din_valid(i_din_valid), .din_ready(i_din_ready),
    .dout_data(i_dout_data), .dout_valid(i_dout_valid), .dout_ready(i_dout_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // Holds rst across two rising edges; returns at a falling edge with rst low.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    din_valid = 1'b1; din_data = 16'hDEAD; dout_ready = 1'b1;
    i_din_valid = 1'b1; i_din_data = 16'hBEEF; i_dout_ready = 1'b1;
    do_reset();
    checks++; if (dout_valid !== 1'b0) $display("FAIL reset_dout_valid: got %b want 0", dout_valid); else passed++;
    checks++; if (din_ready !== 1'b1) $display("FAIL reset_din_ready: got %b want 1", din_ready); else passed++;
    checks++; if (i_dout_valid !== 1'b1) $display("FAIL reset_init_valid: got %b want 1", i_dout_valid); else passed++;
    checks++; if (i_dout_data !== 16'h005A) $display("FAIL reset_init_data: got %h want 005a", i_dout_data); else passed++;
    checks++; if (i_din_ready !== 1'b1) $display("FAIL reset_init_din_ready: got %b want 1", i_din_ready); else passed++;
    din_valid = 1'b0; dout_ready = 1'b0; i_din_valid = 1'b0; i_dout_ready = 1'b0;
    step();
    checks++; if (dout_valid !== 1'b0) $display("FAIL reset_discard_in: got %b want 0", dout_valid); else passed++;
    checks++; if (i_dout_data !== 16'h005A) $display("FAIL reset_discard_init: got %h want 005a", i_dout_data); else passed++;
  endtask

  task automatic test_streaming();
    do_reset();
    dout_ready = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      if (k <= 4) begin
        checks++; if (din_ready !== 1'b1) $display("FAIL stream_din_ready c%0d: got %b want 1", k, din_ready); else passed++;
      end
      if (k >= 1 && k <= 4) begin
        checks++; if (dout_valid !== 1'b1 || dout_data !== 16'(k))
          $display("FAIL stream_out c%0d: got v=%b d=%h want v=1 d=%h", k, dout_valid, dout_data, 16'(k)); else passed++;
      end else begin
        checks++; if (dout_valid !== 1'b0) $display("FAIL stream_idle c%0d: got %b want 0", k, dout_valid); else passed++;
      end
      din_valid = (k < 4);
      din_data  = 16'(k + 1);
      step();
    end
    din_valid = 1'b0; dout_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    dout_ready = 1'b0; din_valid = 1'b1; din_data = 16'h000A;
    step();
    checks++; if (dout_valid !== 1'b1 || dout_data !== 16'h000A) $display("FAIL bp_c1_out: got v=%b d=%h want v=1 d=000a", dout_valid, dout_data); else passed++;
    checks++; if (din_ready !== 1'b1) $display("FAIL bp_c1_ready: got %b want 1", din_ready); else passed++;
    din_data = 16'h000B;
    step();
    checks++; if (din_ready !== 1'b0) $display("FAIL bp_c2_ready: got %b want 0", din_ready); else passed++;
    checks++; if (dout_data !== 16'h000A) $display("FAIL bp_c2_out: got %h want 000a", dout_data); else passed++;
    din_data = 16'h000C;
    step();
    checks++; if (din_ready !== 1'b0) $display("FAIL bp_c3_ready: got %b want 0", din_ready); else passed++;
    checks++; if (dout_valid !== 1'b1 || dout_data !== 16'h000A) $display("FAIL bp_c3_hold: got v=%b d=%h want v=1 d=000a", dout_valid, dout_data); else passed++;
    dout_ready = 1'b1;
    step();
    checks++; if (dout_valid !== 1'b1 || dout_data !== 16'h000B) $display("FAIL bp_c4_out: got v=%b d=%h want v=1 d=000b", dout_valid, dout_data); else passed++;
    checks++; if (din_ready !== 1'b1) $display("FAIL bp_c4_ready: got %b want 1", din_ready); else passed++;
    step();
    checks++; if (dout_valid !== 1'b1 || dout_data !== 16'h000C) $display("FAIL bp_c5_out: got v=%b d=%h want v=1 d=000c", dout_valid, dout_data); else passed++;
    din_valid = 1'b0;
    step();
    checks++; if (dout_valid !== 1'b0) $display("FAIL bp_c6_empty: got %b want 0", dout_valid); else passed++;
    dout_ready = 1'b0;
  endtask

  task automatic test_alternating();
    int  tx = 0;
    int  rx = 0;
    int  cyc = 0;
    logic r0;
    do_reset();
    while (rx < 20 && cyc < 200) begin
      r0 = din_ready;
      dout_ready = ~cyc[0];
      #1;
      checks++; if (din_ready !== r0) $display("FAIL alt_ready_comb c%0d: got %b want %b", cyc, din_ready, r0); else passed++;
      if (dout_valid && dout_ready) begin
        checks++; if (dout_data !== 16'(16'h0100 + rx))
          $display("FAIL alt_data #%0d: got %h want %h", rx, dout_data, 16'(16'h0100 + rx)); else passed++;
        rx++;
      end
      din_valid = (tx < 20);
      din_data  = 16'(16'h0100 + tx);
      if (din_valid && din_ready) tx++;
      step();
      cyc++;
    end
    checks++; if (rx !== 20) $display("FAIL alt_count: got %0d want 20", rx); else passed++;
    din_valid = 1'b0; dout_ready = 1'b1;
    repeat (3) step();
    checks++; if (dout_valid !== 1'b0) $display("FAIL alt_no_dup: got %b want 0", dout_valid); else passed++;
    dout_ready = 1'b0;
  endtask

  task automatic test_reset_in_full();
    do_reset();
    dout_ready = 1'b0; din_valid = 1'b1; din_data = 16'h0011;
    step();
    din_data = 16'h0022;
    step();
    checks++; if (din_ready !== 1'b0) $display("FAIL rf_full: got %b want 0", din_ready); else passed++;
    din_data = 16'h0033; dout_ready = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; din_valid = 1'b0;
    checks++; if (dout_valid !== 1'b0) $display("FAIL rf_dout_valid: got %b want 0", dout_valid); else passed++;
    checks++; if (din_ready !== 1'b1) $display("FAIL rf_din_ready: got %b want 1", din_ready); else passed++;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (dout_valid !== 1'b0) $display("FAIL rf_stale c%0d: got v=%b d=%h want v=0", k, dout_valid, dout_data); else passed++;
    end
    din_valid = 1'b1; din_data = 16'h0044;
    step();
    din_valid = 1'b0;
    checks++; if (dout_valid !== 1'b1 || dout_data !== 16'h0044) $display("FAIL rf_next: got v=%b d=%h want v=1 d=0044", dout_valid, dout_data); else passed++;
    step();
    dout_ready = 1'b0;
  endtask

  task automatic test_init_valid();
    i_dout_ready = 1'b1; i_din_valid = 1'b0;
    do_reset();
    checks++; if (i_dout_valid !== 1'b1 || i_dout_data !== 16'h005A) $display("FAIL init_first: got v=%b d=%h want v=1 d=005a", i_dout_valid, i_dout_data); else passed++;
    i_din_valid = 1'b1; i_din_data = 16'h0061;
    step();
    checks++; if (i_dout_valid !== 1'b1 || i_dout_data !== 16'h0061) $display("FAIL init_second: got v=%b d=%h want v=1 d=0061", i_dout_valid, i_dout_data); else passed++;
    i_din_data = 16'h0062;
    step();
    checks++; if (i_dout_valid !== 1'b1 || i_dout_data !== 16'h0062) $display("FAIL init_third: got v=%b d=%h want v=1 d=0062", i_dout_valid, i_dout_data); else passed++;
    i_din_valid = 1'b0;
    step();
    checks++; if (i_dout_valid !== 1'b0) $display("FAIL init_drained: got %b want 0", i_dout_valid); else passed++;
    i_dout_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] q[$];
    int   tx = 0;
    int   rx = 0;
    int   cyc = 0;
    logic r0;
    logic took;
    do_reset();
    din_valid = 1'b0;
    while (rx < 10000 && cyc < 60000) begin
      checks++; if (dout_valid !== (q.size() != 0)) $display("FAIL rnd_valid c%0d: got %b want %b", cyc, dout_valid, q.size() != 0); else passed++;
      checks++; if (din_ready !== (q.size() < 2)) $display("FAIL rnd_ready c%0d: got %b want %b", cyc, din_ready, q.size() < 2); else passed++;
      r0 = din_ready;
      dout_ready = 1'($urandom_range(0, 1));
      #1;
      checks++; if (din_ready !== r0) $display("FAIL rnd_ready_comb c%0d: got %b want %b", cyc, din_ready, r0); else passed++;
      if (!din_valid && tx < 10000 && $urandom_range(0, 1) == 1) begin
        din_valid = 1'b1;
        din_data  = 16'($urandom);
      end
      if (dout_valid && dout_ready) begin
        checks++;
        if (q.size() == 0) $display("FAIL rnd_data #%0d: got %h want nothing", rx, dout_data);
        else if (dout_data !== q[0]) $display("FAIL rnd_data #%0d: got %h want %h", rx, dout_data, q[0]);
        else passed++;
        if (q.size() != 0) void'(q.pop_front());
        rx++;
      end
      took = din_valid && din_ready;
      if (took) begin
        q.push_back(din_data);
        tx++;
      end
      step();
      if (took) din_valid = 1'b0;
      cyc++;
    end
    checks++; if (rx !== 10000) $display("FAIL rnd_count: got %0d want 10000", rx); else passed++;
    din_valid = 1'b0; dout_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_alternating();
    test_reset_in_full();
    test_init_valid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/skid_reg.md
Name: skid_reg

Overview:
Pipeline stage on the dti valid/ready interface that registers the backward (ready) path as well as the forward (valid/data) path. It breaks the combinational dout.ready -> din.ready chain that a forward-only data register leaves in place. Two-entry skid buffer (main + skid register) sustains one transfer per cycle under full throughput. It is placed between long-chained gears, where both handshake directions need timing closure.

Parameters:
DIN, 16, data width in bits; also the width of din.data and dout.data.
INIT, 0, value loaded into the main data register on reset when INIT_VALID=1.
INIT_VALID, 0, when 1 the stage leaves reset holding one valid item INIT (state BUSY).

Ports:
clk  input  1  clock
rst  input  1  reset
din.data  input  DIN  consumer-side data
din.valid  input  1  consumer-side valid
din.ready  output  1  consumer-side ready, driven from a flop
dout.data  output  DIN  producer-side data, driven from the main register
dout.valid  output  1  producer-side valid, driven from state
dout.ready  input  1  producer-side ready

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. din is a dti.consumer, dout is a dti.producer.
- Signal definitions:
  - in_xfer = din.valid & din.ready.
  - out_xfer = dout.valid & dout.ready.
- States:
  - EMPTY: nothing held.
  - BUSY: main register valid, skid register empty.
  - FULL: main and skid registers both valid.
- Output decode:
  - din.ready = (state != FULL).
  - dout.valid = (state != EMPTY).
  - dout.data = main register.
  - All three come only from flops. There is no combinational path din.* -> dout.* or dout.ready -> din.ready.
- Reset values:
  - INIT_VALID=0: state EMPTY, dout.valid=0, din.ready=1.
  - INIT_VALID=1: state BUSY, main register=INIT, dout.valid=1, din.ready=1.
  - The skid register is not reset.
- Reset-cycle handling: any in_xfer or out_xfer in a cycle where rst=1 is discarded. The reset state wins.
- Transitions:
  - EMPTY, in_xfer: main<=din.data, go to BUSY. Otherwise stay.
  - BUSY, in_xfer and out_xfer: main<=din.data, stay BUSY.
  - BUSY, in_xfer only: skid<=din.data, go to FULL.
  - BUSY, out_xfer only: go to EMPTY.
  - BUSY, neither: hold.
  - FULL, out_xfer: main<=skid, go to BUSY. in_xfer cannot occur because din.ready=0.
  - FULL, no out_xfer: hold.
- Latency and throughput:
  - Latency din->dout is 1 cycle: an item accepted in cycle N is visible on dout in cycle N+1.
  - Steady-state throughput is 1 item/cycle when dout.ready is held high.
- din.ready drops the cycle after the skid register fills. It rises the cycle after an out_xfer in FULL.
- Protocol obligations on dout:
  - Once asserted, dout.valid stays high until out_xfer.
  - dout.data is stable while dout.valid & !dout.ready.
  - Order is preserved; no item is lost or duplicated.
- din contract: the upstream producer holds din.valid and din.data stable until in_xfer. The block may rely on this but does not check it.
- Data registers update only on the transitions listed above. Data width is passed through unchanged, with no arithmetic.

Test Plan:
1. Streaming: reset (INIT_VALID=0), dout.ready=1, drive 0x0001..0x0004 back-to-back from cycle 0 -> dout shows 0x0001..0x0004 in cycles 1..4, one per cycle; din.ready=1 throughout.
2. Backpressure fill/drain: dout.ready=0, offer 0xA, 0xB, 0xC -> 0xA and 0xB accepted, din.ready=0 the cycle after 0xB, 0xC held; then dout.ready=1 -> dout emits 0xA, 0xB, 0xC in order, and din.ready returns to 1 the cycle after 0xA leaves.
3. Alternating dout.ready (1,0,1,0,...) with continuous din.valid over 20 items -> all 20 received in order, no duplicates; din.ready never changes in the same cycle as a dout.ready edge.
4. Reset in FULL: fill with 0x11 and 0x22, assert rst for 1 cycle while dout.ready=1 -> next cycle dout.valid=0, din.ready=1; 0x11 and 0x22 never appear afterwards.
5. INIT_VALID=1, INIT=0x5A: release reset with dout.ready=1 -> first out_xfer carries 0x5A, then incoming items follow in order.
6. Random valid/ready at 50%/50% over 10000 items with a scoreboard -> zero mismatches; the formal/assert check shows no combinational path from dout.ready to din.ready.
